// File: rtl/switch_input_pkg.sv
// Shared MMIO package for the board I/O peripherals. It holds the parameter
// defaults for the switch/button input block, the register offsets of the
// LED and switch blocks, and the read-select decoding.
package switch_input_pkg;

  // Parameter defaults for the switch/button input block.
  localparam int SW_WIDTH_DEF   = 24;
  localparam int BTN_WIDTH_DEF  = 5;
  localparam int SAMPLE_DIV_DEF = 50000;
  localparam int STABLE_CNT_DEF = 3;

  // MMIO register offsets within the I/O window.
  localparam logic [7:0] LED_LOW_OFS  = 8'h60;
  localparam logic [7:0] LED_HIGH_OFS = 8'h62;
  localparam logic [7:0] SW_LOW_OFS   = 8'h70;
  localparam logic [7:0] SW_HIGH_OFS  = 8'h72;
  localparam logic [7:0] SW_BTN_OFS   = 8'h74;

  // Effective read selection after priority resolution.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LOW  = 2'd1,
    SEL_HIGH = 2'd2,
    SEL_BTN  = 2'd3
  } rd_sel_e;

  // The low select wins over the high select, which wins over the button select.
  function automatic rd_sel_e decode_sel(input logic lo, input logic hi, input logic btn);
    if (lo)       return SEL_LOW;
    else if (hi)  return SEL_HIGH;
    else if (btn) return SEL_BTN;
    else          return SEL_NONE;
  endfunction

endpackage

// File: rtl/switch_input_debounce_vec.sv
// Vector debouncer. Each bit passes through a two-flop synchroniser. On
// every sample tick, the synchronised value shifts into a per-bit history.
// The debounced level follows the history only when all STABLE_CNT samples
// agree. Otherwise it holds its previous value.
module debounce_vec
  import switch_input_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic             sw_clk,
  input  logic             swrst,
  input  logic             sample_tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  logic [WIDTH-1:0]      sync1;
  logic [WIDTH-1:0]      sync2;
  logic [STABLE_CNT-1:0] hist     [WIDTH];
  logic [STABLE_CNT-1:0] hist_nxt [WIDTH];
  logic [WIDTH-1:0]      level_nxt;

  // Bring the asynchronous pins into the sw_clk domain.
  always_ff @(posedge sw_clk or negedge swrst) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    if (!swrst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Shift on a tick, then set or clear the level only when the history is unanimous.
  always_comb begin
    // NOTE: defaults first so that every path assigns every output and no latch is inferred.
    hist_nxt  = hist;
    level_nxt = level;
    if (sample_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        hist_nxt[i] = {hist[i][STABLE_CNT-2:0], sync2[i]};
        if (&hist_nxt[i])       level_nxt[i] = 1'b1;
        else if (~|hist_nxt[i]) level_nxt[i] = 1'b0;
      end
    end
  end

  // Register the histories and levels. On reset, any partial history is discarded.
  always_ff @(posedge sw_clk or negedge swrst) begin
    if (!swrst) begin
      // NOTE: the history array is reset explicitly because a stale partial history would bias the next decision.
      for (int i = 0; i < WIDTH; i++) hist[i] <= '0;
      level <= '0;
    end else begin
      hist  <= hist_nxt;
      level <= level_nxt;
    end
  end

endmodule

// File: rtl/switch_input.sv
// Memory-mapped switch/button input peripheral. It debounces the DIP
// switches and push-buttons and latches button presses as sticky flags that
// are cleared on read. It returns 16-bit read data to memorio using the same
// low/high select scheme as the LED block.
module switch_input
  import switch_input_pkg::*;
#(
  parameter int SW_WIDTH   = SW_WIDTH_DEF,
  parameter int BTN_WIDTH  = BTN_WIDTH_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic                 sw_clk,
  input  logic                 swrst,
  input  logic                 swread,
  input  logic                 swlow,
  input  logic                 swhigh,
  input  logic                 swbtn,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [15:0]          swrdata,
  output logic [SW_WIDTH-1:0]  sw_level,
  output logic [BTN_WIDTH-1:0] btn_level
);

  localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  logic [PW-1:0]        presc;
  logic                 sample_tick;
  logic [BTN_WIDTH-1:0] btn_prev;
  logic [BTN_WIDTH-1:0] btn_rise;
  logic [BTN_WIDTH-1:0] flags;
  rd_sel_e              sel;
  logic                 clr_flags;

  assign sample_tick = (presc == PW'(SAMPLE_DIV - 1));

  // The prescaler counts 0..SAMPLE_DIV-1 and produces one tick per wrap.
  always_ff @(posedge sw_clk or negedge swrst) begin
    if (!swrst)           presc <= '0;
    else if (sample_tick) presc <= '0;
    else                  presc <= presc + PW'(1);
  end

  debounce_vec #(
    .WIDTH      (SW_WIDTH),
    .STABLE_CNT (STABLE_CNT)
  ) u_sw_db (
    .sw_clk      (sw_clk),
    .swrst       (swrst),
    .sample_tick (sample_tick),
    .raw         (sw_in),
    .level       (sw_level)
  );

  debounce_vec #(
    .WIDTH      (BTN_WIDTH),
    .STABLE_CNT (STABLE_CNT)
  ) u_btn_db (
    .sw_clk      (sw_clk),
    .swrst       (swrst),
    .sample_tick (sample_tick),
    .raw         (btn_in),
    .level       (btn_level)
  );

  assign sel       = decode_sel(swlow, swhigh, swbtn);
  assign clr_flags = swread && (sel == SEL_BTN);
  assign btn_rise  = btn_level & ~btn_prev;

  // Sticky press flags. A new press in the same cycle as a clearing read still sets its flag.
  always_ff @(posedge sw_clk or negedge swrst) begin
    if (!swrst) begin
      btn_prev <= '0;
      flags    <= '0;
    end else begin
      btn_prev <= btn_level;
      flags    <= (clr_flags ? '0 : flags) | btn_rise;
    end
  end

  // The read mux is combinational from registered state and returns zero while reset is held.
  always_comb begin
    swrdata = 16'h0000;
    if (swrst) begin
      case (sel)
        SEL_LOW:  swrdata = sw_level[15:0];
        SEL_HIGH: swrdata = 16'(sw_level[SW_WIDTH-1:16]);
        SEL_BTN:  swrdata = 16'(flags);
        default:  swrdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_input.sv
// Self-checking bench for switch_input with SAMPLE_DIV=4 and STABLE_CNT=3.
// A reference model tracks the raw pin values seen at every clock edge. It
// takes a sample every 4th edge, and a debounced bit changes only when the
// last three samples agree. Button flags accumulate press edges and are
// cleared by button reads.
module tb_switch_input;

  localparam int SWW  = 24;
  localparam int BTW  = 5;
  localparam int DIV  = 4;
  localparam int NSTB = 3;

  logic            sw_clk;
  logic            swrst;
  logic            swread;
  logic            swlow;
  logic            swhigh;
  logic            swbtn;
  logic [SWW-1:0]  sw_in;
  logic [BTW-1:0]  btn_in;
  logic [15:0]     swrdata;
  logic [SWW-1:0]  sw_level;
  logic [BTW-1:0]  btn_level;

  int n_cmp = 0;
  int n_err = 0;

  // Reference-model state
  logic [SWW-1:0] m_sw_lvl;
  logic [BTW-1:0] m_btn_lvl;
  logic [BTW-1:0] m_btn_prev;
  logic [BTW-1:0] m_flags;
  int             m_k;
  logic [SWW-1:0] raw_sw  [$];
  logic [BTW-1:0] raw_btn [$];
  logic [SWW-1:0] smp_sw  [$];
  logic [BTW-1:0] smp_btn [$];

  switch_input #(
    .SW_WIDTH   (SWW),
    .BTN_WIDTH  (BTW),
    .SAMPLE_DIV (DIV),
    .STABLE_CNT (NSTB)
  ) dut (
    .sw_clk    (sw_clk),
    .swrst     (swrst),
    .swread    (swread),
    .swlow     (swlow),
    .swhigh    (swhigh),
    .swbtn     (swbtn),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .swrdata   (swrdata),
    .sw_level  (sw_level),
    .btn_level (btn_level)
  );

  initial sw_clk = 1'b0;
  always #5 sw_clk = ~sw_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sw_lvl = '0; m_btn_lvl = '0; m_btn_prev = '0; m_flags = '0; m_k = 0;
    raw_sw.delete(); raw_btn.delete(); smp_sw.delete(); smp_btn.delete();
    for (int i = 0; i < NSTB; i++) begin
      smp_sw.push_back('0);
      smp_btn.push_back('0);
    end
  endtask

  // Advance the model by one clock edge. The inputs are the pin values present at that edge.
  task automatic model_edge(input logic [SWW-1:0] sw, input logic [BTW-1:0] btn, input logic clr);
    logic [SWW-1:0] a1_sw, a0_sw;
    logic [BTW-1:0] a1_b, a0_b;
    // A flag is raised by a button level that rose at the previous edge.
    m_flags    = (clr ? '0 : m_flags) | (m_btn_lvl & ~m_btn_prev);
    m_btn_prev = m_btn_lvl;
    raw_sw.push_back(sw);
    raw_btn.push_back(btn);
    if (m_k % DIV == DIV - 1) begin
      // Two sync stages: the sampled value is the pin value from two edges earlier.
      smp_sw.push_back(raw_sw[m_k-2]);   void'(smp_sw.pop_front());
      smp_btn.push_back(raw_btn[m_k-2]); void'(smp_btn.pop_front());
      a1_sw = smp_sw[0] & smp_sw[1] & smp_sw[2];
      a0_sw = ~(smp_sw[0] | smp_sw[1] | smp_sw[2]);
      a1_b  = smp_btn[0] & smp_btn[1] & smp_btn[2];
      a0_b  = ~(smp_btn[0] | smp_btn[1] | smp_btn[2]);
      m_sw_lvl  = (m_sw_lvl & ~a0_sw) | a1_sw;
      m_btn_lvl = (m_btn_lvl & ~a0_b) | a1_b;
    end
    m_k++;
  endtask

  // Run one clock cycle, starting and ending just after a falling edge.
  task automatic cyc(input logic [SWW-1:0] sw, input logic [BTW-1:0] btn,
                     input logic rd, input logic lo, input logic hi, input logic bt,
                     output logic [15:0] obs);
    logic [15:0] exp_rd;
    sw_in = sw; btn_in = btn; swread = rd; swlow = lo; swhigh = hi; swbtn = bt;
    if (lo)      exp_rd = m_sw_lvl[15:0];
    else if (hi) exp_rd = {8'h00, m_sw_lvl[23:16]};
    else if (bt) exp_rd = {11'h000, m_flags};
    else         exp_rd = 16'h0000;
    #1;
    obs = swrdata;
    check("swrdata", 32'(swrdata), 32'(exp_rd));
    @(posedge sw_clk);
    model_edge(sw, btn, rd && bt && !lo && !hi);
    #1;
    check("sw_level", 32'(sw_level), 32'(m_sw_lvl));
    check("btn_level", 32'(btn_level), 32'(m_btn_lvl));
    @(negedge sw_clk);
  endtask

  task automatic idle(input logic [SWW-1:0] sw, input logic [BTW-1:0] btn, input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) cyc(sw, btn, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [SWW-1:0] sw_cur;
    logic [BTW-1:0] btn_cur;
    int sw_hold, btn_hold, waited;
    logic found;

    // The bench holds reset with the low select asserted; everything must read 0.
    swrst = 1'b0; swread = 1'b0; swlow = 1'b1; swhigh = 1'b0; swbtn = 1'b0;
    sw_in = 24'hFFFFFF; btn_in = '1;
    repeat (3) @(negedge sw_clk);
    #1;
    check("rst_rdata", 32'(swrdata), 32'h0);
    check("rst_sw_level", 32'(sw_level), 32'h0);
    check("rst_btn_level", 32'(btn_level), 32'h0);
    @(negedge sw_clk);
    swrst = 1'b1;
    model_reset();

    // A stable switch pattern appears after three samples.
    sw_cur = 24'hA5C3F0; btn_cur = '0;
    idle(sw_cur, btn_cur, 11);
    check("sw_latency_before", 32'(sw_level), 32'h0);
    idle(sw_cur, btn_cur, 1);
    check("sw_latency_after", 32'(sw_level), 32'hA5C3F0);
    idle(sw_cur, btn_cur, 4);
    cyc(sw_cur, btn_cur, 1'b1, 1'b1, 1'b0, 1'b0, rd);
    check("read_low", 32'(rd), 32'hC3F0);
    cyc(sw_cur, btn_cur, 1'b1, 1'b0, 1'b1, 1'b0, rd);
    check("read_high", 32'(rd), 32'h00A5);

    // A one-tick glitch on sw_in[0] must never reach the level.
    idle(sw_cur | 24'h1, btn_cur, DIV);
    for (int i = 0; i < 16; i++) begin
      idle(sw_cur, btn_cur, 1);
      check("glitch_bit0", 32'(sw_level[0]), 32'h0);
    end

    // Press button 2 for 5 ticks and release, then read the flags twice.
    idle(sw_cur, 5'b00100, 5 * DIV);
    idle(sw_cur, 5'b00000, 16);
    cyc(sw_cur, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, rd);
    check("btn_read1", 32'(rd), 32'h0004);
    cyc(sw_cur, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, rd);
    check("btn_read2", 32'(rd), 32'h0000);

    // A press edge that lands on a clearing read must survive the read.
    found = 1'b0;
    waited = 0;
    while (!found && waited < 40) begin
      idle(sw_cur, 5'b00100, 1);
      waited++;
      found = m_btn_lvl[2] && !m_btn_prev[2];
    end
    check("coincide_reached", 32'(found), 32'h1);
    cyc(sw_cur, 5'b00100, 1'b1, 1'b0, 1'b0, 1'b1, rd);
    check("coincide_old", 32'(rd), 32'h0000);
    cyc(sw_cur, 5'b00100, 1'b1, 1'b0, 1'b0, 1'b1, rd);
    check("coincide_next", 32'(rd), 32'h0004);
    idle(sw_cur, 5'b00000, 16);

    // When the low and button selects are both asserted, the low select wins and the flags are kept.
    idle(sw_cur, 5'b00001, 5 * DIV);
    idle(sw_cur, 5'b00000, 16);
    cyc(sw_cur, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b1, rd);
    check("prio_low", 32'(rd), 32'hC3F0);
    cyc(sw_cur, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, rd);
    check("peek_no_read", 32'(rd), 32'h0001);
    cyc(sw_cur, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, rd);
    check("flag_kept", 32'(rd), 32'h0001);
    cyc(sw_cur, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, rd);
    check("flag_cleared", 32'(rd), 32'h0000);

    // An asynchronous reset mid-debounce discards the partial history.
    sw_cur = 24'h123456;
    idle(sw_cur, 5'b00010, 7);
    swlow = 1'b1;
    @(posedge sw_clk);
    #2 swrst = 1'b0;
    #1;
    check("async_rdata", 32'(swrdata), 32'h0);
    check("async_sw_level", 32'(sw_level), 32'h0);
    check("async_btn_level", 32'(btn_level), 32'h0);
    @(negedge sw_clk);
    swrst = 1'b1;
    model_reset();
    idle(sw_cur, 5'b00000, 11);
    check("rerun_before", 32'(sw_level), 32'h0);
    idle(sw_cur, 5'b00000, 1);
    check("rerun_after", 32'(sw_level), 32'h123456);

    // Random phase: random hold lengths, including glitches, with random reads and selects.
    sw_hold = 0; btn_hold = 0; btn_cur = '0;
    for (int i = 0; i < 800; i++) begin
      if (sw_hold == 0) begin
        sw_cur  = SWW'($urandom);
        sw_hold = $urandom_range(1, 20);
      end
      if (btn_hold == 0) begin
        btn_cur  = BTW'($urandom);
        btn_hold = $urandom_range(1, 24);
      end
      cyc(sw_cur, btn_cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), rd);
      sw_hold--;
      btn_hold--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_input.md
Name: switch_input

Overview:
- Memory-mapped input peripheral: the read-side counterpart of the LED output block.
- Takes the 24 board DIP switches and 5 push-buttons and synchronises and debounces them.
- Latches button press events as sticky flags.
- The CPU reads the results through MMIO with the same low/high select scheme the LED block uses for writes.
- Sits beside the LED block under the MMIO decoder and returns read data to memorio.

Parameters:
- SW_WIDTH, 24, number of switch inputs (16 < SW_WIDTH <= 32).
- BTN_WIDTH, 5, number of button inputs (<= 16).
- SAMPLE_DIV, 50000, sw_clk cycles per debounce sample tick (>= 2).
- STABLE_CNT, 3, consecutive equal samples required to change a debounced bit (>= 2).

Ports:
- sw_clk  input  1  peripheral clock; all state changes on its rising edge.
- swrst  input  1  reset, asynchronous, active-low.
- swread  input  1  CPU read strobe, active high, one cycle per load.
- swlow  input  1  select: low 16 switch bits.
- swhigh  input  1  select: switch bits [SW_WIDTH-1:16].
- swbtn  input  1  select: button event flags (read-to-clear).
- sw_in  input  SW_WIDTH  raw switch pins (asynchronous).
- btn_in  input  BTN_WIDTH  raw button pins, pressed = 1 (asynchronous).
- swrdata  output  16  read data to memorio.
- sw_level  output  SW_WIDTH  debounced switch vector (debug and top-level use).
- btn_level  output  BTN_WIDTH  debounced button levels.

Behaviour:
- Reset (swrst low, async): prescaler, sync flops, sample histories, sw_level, btn_level and flags all go to 0. swrdata reads 0 while reset is asserted. Reset mid-debounce discards the partial history.
- Synchroniser: two flops per input bit. Raw changes reach the sync output 2 cycles later.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - sample_tick is high for one cycle while the count equals SAMPLE_DIV-1.
- Debounce:
  - On sample_tick, each bit shifts its synced value into a STABLE_CNT-bit history.
  - History all ones sets the debounced bit to 1; all zeros sets it to 0; any other pattern holds the previous value.
  - Worst-case latency from a stable raw change to the level update: 2 + STABLE_CNT*SAMPLE_DIV cycles.
  - Glitches shorter than STABLE_CNT-1 ticks are never visible.
- Button flags:
  - Flag[i] sets on the cycle btn_level[i] goes 0 to 1.
  - Flag[i] clears on a rising edge where swread && swbtn.
  - If a set and a clear coincide, the set wins, so no press is lost.
  - Release does not clear a flag.
  - Multiple presses before a read collapse to a single flag.
- Read mux (combinational from registered state, zero added latency):
  - swlow: sw_level[15:0].
  - swhigh: zero-extended sw_level[SW_WIDTH-1:16].
  - swbtn: zero-extended flags.
  - No select: 16'h0000.
- Select priority: swlow > swhigh > swbtn if several are asserted. A flag clear occurs only when swbtn is the effective selection.
- A read without swread returns data but has no side effects.
- Selects without swread never clear flags.

Decomposition:
- Shared package (team MMIO package): defaults for SW_WIDTH, BTN_WIDTH, SAMPLE_DIV, STABLE_CNT; the MMIO offsets for the low, high and button registers, alongside the LED offsets.
- Sub-module debounce_vec: parameterised width. Contains the 2-flop sync plus the history/level logic and takes sample_tick as an input.
- The top instantiates debounce_vec twice (switches, buttons) and one prescaler.

Test Plan (bench uses SAMPLE_DIV=4, STABLE_CNT=3):
- Reset then hold sw_in=24'hA5C3F0 stable -> sw_level is 0 until about 14 cycles, then 24'hA5C3F0. Read swlow -> 16'hC3F0; swhigh -> 16'h00A5.
- Toggle sw_in[0] high for 1 tick then low -> sw_level[0] stays 0 throughout.
- Press btn_in[2] for 5 ticks and release, then read swbtn with swread -> 16'h0004. A second read -> 16'h0000.
- Button rising edge on the same cycle as a swread&&swbtn -> that read returns the old flags and the flag stays set afterwards. The next read returns 16'h0004.
- swlow and swbtn asserted together with swread, flags=5'b00001 -> swrdata = switch low bits and the flag is not cleared.
- Assert swrst low mid-debounce and asynchronously (between clock edges) -> all outputs 0 immediately. After release, the previously half-sampled input needs the full 3 ticks again.
